event_readout_scheduler: RTL and testbench

Sequences readout of buffered trigger events out of the event memory, one event at a time, in trigger order. Sits between the trigger-accept logic and the readout engine. Allocates a ring slot per accepted trigger, issues one read request per slot with a valid/ready handshake, and retires the slot on read completion. Also owns occupancy, the stop/continue throttle and error flags.

---
 rtl/evt_sched_pkg.sv | 18 +
 rtl/evt_occupancy_counter.sv | 60 ++++++
 rtl/event_readout_scheduler.sv | 171 +++++++++++++++++
 tb/tb_event_readout_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/evt_sched_pkg.sv
// Shared definitions for the event readout scheduler: FSM state encoding,
// default sizing and the slot/occupancy widths derived from the default ring size.
package evt_sched_pkg;

  localparam int unsigned N_SLOT_DEF       = 64;
  localparam int unsigned MAX_NEVENT_DEF   = 45;
  localparam int unsigned READ_TIMEOUT_DEF = 4096;

  localparam int unsigned SLOT_W = $clog2(N_SLOT_DEF);
  localparam int unsigned OCC_W  = SLOT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/evt_occupancy_counter.sv
// Occupancy counter for the event ring: counts stored, not-yet-retired events,
// flags the full condition and drives the stop throttle with hysteresis around
// MAX_NEVENT (set above, clear below, hold when equal).
module evt_occupancy_counter #(
  parameter int unsigned N_SLOT     = 64,
  parameter int unsigned MAX_NEVENT = 45,
  parameter int unsigned OCC_W      = $clog2(N_SLOT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc_req,
  input  logic             dec,
  output logic [OCC_W-1:0] count,
  output logic             full,
  output logic             inc_ok,
  output logic             stop
);

  logic [OCC_W-1:0] count_q, count_d;
  logic             stop_q, stop_d;

  // Next count and throttle state; stop looks at the registered count so it lags by a cycle
  always_comb begin
    full    = (count_q == OCC_W'(N_SLOT));
    inc_ok  = inc_req && !full;
    count_d = count_q;
    stop_d  = stop_q;
    if (clr) begin
      count_d = '0;
      stop_d  = 1'b0;
    end else begin
      if (inc_ok && !dec) begin
        count_d = count_q + 1'b1;
      end else if (!inc_ok && dec) begin
        count_d = count_q - 1'b1;
      end
      if (count_q > OCC_W'(MAX_NEVENT)) begin
        stop_d = 1'b1;
      end else if (count_q < OCC_W'(MAX_NEVENT)) begin
        stop_d = 1'b0;
      end
    end
  end

  // Occupancy and throttle registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      stop_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      stop_q  <= stop_d;
    end
  end

  assign count = count_q;
  assign stop  = stop_q;

endmodule

// File: rtl/event_readout_scheduler.sv
// Event readout scheduler: allocates a ring slot per accepted trigger, issues
// one read request per stored slot (valid/ready), retires the slot on
// read_complete and keeps sticky error flags.
// Optional read watchdog: define EVTSCHED_TIMEOUT_EN to retire a slot whose
// read does not complete within READ_TIMEOUT cycles of WAIT.
module event_readout_scheduler
  import evt_sched_pkg::*;
#(
  parameter int unsigned N_SLOT       = N_SLOT_DEF,
  parameter int unsigned MAX_NEVENT   = MAX_NEVENT_DEF,
  parameter int unsigned READ_TIMEOUT = READ_TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      live_rising,
  input  logic                      trig_accepted,
  input  logic                      read_complete,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [$clog2(N_SLOT)-1:0] rd_slot,
  output logic [$clog2(N_SLOT)-1:0] wr_slot,
  output logic [$clog2(N_SLOT):0]   n_pileup,
  output logic                      stop,
  output logic                      write_overflow,
  output logic                      read_overflow,
  output logic                      timeout_err
);

  localparam int unsigned SW = $clog2(N_SLOT);
  localparam int unsigned OW = SW + 1;

  sched_state_e   state_q, state_d;
  logic [SW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]  wr_ptr_q, wr_ptr_d;
  logic           write_overflow_q, write_overflow_d;
  logic           read_overflow_q, read_overflow_d;
  logic           retire;
  logic           inc_ok;
  logic           full;
  logic [OW-1:0]  occ;

`ifdef EVTSCHED_TIMEOUT_EN
  localparam int unsigned WD_W = (READ_TIMEOUT > 1) ? $clog2(READ_TIMEOUT) : 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  evt_occupancy_counter #(
    .N_SLOT     (N_SLOT),
    .MAX_NEVENT (MAX_NEVENT),
    .OCC_W      (OW)
  ) u_occ (
    .clk     (clk),
    .rst     (rst),
    .clr     (live_rising),
    .inc_req (trig_accepted),
    .dec     (retire),
    .count   (occ),
    .full    (full),
    .inc_ok  (inc_ok),
    .stop    (stop)
  );

  // Read FSM, ring pointers, sticky flags and watchdog; live_rising overrides everything
  always_comb begin
    state_d          = state_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    retire           = 1'b0;
    rd_valid         = 1'b0;
    write_overflow_d = write_overflow_q | (trig_accepted & full);
    read_overflow_d  = read_overflow_q | (read_complete & (state_q != ST_WAIT));
`ifdef EVTSCHED_TIMEOUT_EN
    wd_d      = '0;
    timeout_d = timeout_q;
`endif

    if (inc_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (occ != '0) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (read_complete) begin
          retire   = 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
          state_d  = ST_IDLE;
        end
`ifdef EVTSCHED_TIMEOUT_EN
        else if (wd_q == WD_W'(READ_TIMEOUT - 1)) begin
          retire    = 1'b1;
          timeout_d = 1'b1;
          rd_ptr_d  = rd_ptr_q + 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (live_rising) begin
      state_d          = ST_IDLE;
      rd_ptr_d         = '0;
      wr_ptr_d         = '0;
      retire           = 1'b0;
      rd_valid         = 1'b0;
      write_overflow_d = 1'b0;
      read_overflow_d  = 1'b0;
`ifdef EVTSCHED_TIMEOUT_EN
      wd_d      = '0;
      timeout_d = 1'b0;
`endif
    end
  end

  // State, pointer and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      write_overflow_q <= 1'b0;
      read_overflow_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      write_overflow_q <= write_overflow_d;
      read_overflow_q  <= read_overflow_d;
    end
  end

`ifdef EVTSCHED_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign rd_slot        = rd_ptr_q;
  assign wr_slot        = wr_ptr_q;
  assign n_pileup       = occ;
  assign write_overflow = write_overflow_q;
  assign read_overflow  = read_overflow_q;

endmodule

// File: tb/tb_event_readout_scheduler.sv
// Self-checking bench for event_readout_scheduler: expected read slots are
// queued as triggers are issued and popped by a monitor at every handshake;
// occupancy, throttle and flags are checked against hand-computed values.
module tb_event_readout_scheduler;
  import evt_sched_pkg::*;

  localparam int NS  = 64;
  localparam int RTO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              live_rising;
  logic              trig_accepted;
  logic              read_complete;
  logic              rd_valid;
  logic              rd_ready;
  logic [SLOT_W-1:0] rd_slot;
  logic [SLOT_W-1:0] wr_slot;
  logic [OCC_W-1:0]  n_pileup;
  logic              stop;
  logic              write_overflow;
  logic              read_overflow;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int mdl_wr = 0;
  int mdl_occ = 0;
  bit mdl_waiting = 1'b0;

  event_readout_scheduler #(
    .N_SLOT       (NS),
    .MAX_NEVENT   (45),
    .READ_TIMEOUT (RTO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .live_rising    (live_rising),
    .trig_accepted  (trig_accepted),
    .read_complete  (read_complete),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_slot        (rd_slot),
    .wr_slot        (wr_slot),
    .n_pileup       (n_pileup),
    .stop           (stop),
    .write_overflow (write_overflow),
    .read_overflow  (read_overflow),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One clock of stimulus; the bench model tracks ring order and occupancy
  task automatic applyStimulus(input bit trig, input bit rc, input bit rdy, input bit live);
    trig_accepted = trig;
    read_complete = rc;
    rd_ready      = rdy;
    live_rising   = live;
    cyc(1);
    trig_accepted = 1'b0;
    read_complete = 1'b0;
    rd_ready      = 1'b0;
    live_rising   = 1'b0;
    if (live) begin
      exp_q.delete();
      mdl_wr      = 0;
      mdl_occ     = 0;
      mdl_waiting = 1'b0;
    end else begin
      if (rc && mdl_waiting) begin
        mdl_occ--;
        mdl_waiting = 1'b0;
      end
      if (trig && mdl_occ < NS) begin
        exp_q.push_back(mdl_wr);
        mdl_wr = (mdl_wr + 1) % NS;
        mdl_occ++;
      end
    end
  endtask

  // Monitor: every accepted read request must name the oldest outstanding slot
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL handshake with empty scoreboard: rd_slot %0d, expected no request", rd_slot);
      end else begin
        checkOutput("rd_slot at handshake", int'(rd_slot), exp_q.pop_front());
        mdl_waiting = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global time limit: simulation still running, expected finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    rst           = 1'b1;
    live_rising   = 1'b0;
    trig_accepted = 1'b0;
    read_complete = 1'b0;
    rd_ready      = 1'b0;
    cyc(3);
    checkOutput("reset n_pileup", int'(n_pileup), 0);
    checkOutput("reset rd_valid", int'(rd_valid), 0);
    checkOutput("reset wr_slot", int'(wr_slot), 0);
    checkOutput("reset rd_slot", int'(rd_slot), 0);
    checkOutput("reset stop", int'(stop), 0);
    checkOutput("reset flags", int'({write_overflow, read_overflow, timeout_err}), 0);
    rst = 1'b0;
    cyc(1);

    $display("[TB] single event latency");
    applyStimulus(1, 0, 0, 0);
    checkOutput("single n_pileup t+1", int'(n_pileup), 1);
    checkOutput("single wr_slot t+1", int'(wr_slot), 1);
    checkOutput("single rd_valid t+1", int'(rd_valid), 0);
    cyc(1);
    checkOutput("single rd_valid t+2", int'(rd_valid), 1);
    checkOutput("single rd_slot t+2", int'(rd_slot), 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("rd_valid after handshake", int'(rd_valid), 0);
    cyc(2);
    applyStimulus(0, 1, 0, 0);
    checkOutput("single n_pileup t+6", int'(n_pileup), 0);
    checkOutput("single rd_slot t+6", int'(rd_slot), 1);
    checkOutput("no read_overflow in WAIT", int'(read_overflow), 0);

    $display("[TB] burst of 46 and stop hysteresis");
    for (int i = 0; i < 46; i++) applyStimulus(1, 0, 0, 0);
    checkOutput("burst n_pileup", int'(n_pileup), 46);
    checkOutput("stop not yet set", int'(stop), 0);
    cyc(1);
    checkOutput("stop set one cycle later", int'(stop), 1);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("burst n_pileup 45", int'(n_pileup), 45);
    cyc(1);
    checkOutput("stop held at 45", int'(stop), 1);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("burst n_pileup 44", int'(n_pileup), 44);
    checkOutput("stop still 1 before update", int'(stop), 1);
    cyc(1);
    checkOutput("stop cleared below 45", int'(stop), 0);

    $display("[TB] live_rising during ISSUE");
    live_rising = 1'b1;
    rd_ready    = 1'b1;
    #1;
    checkOutput("rd_valid gated by live_rising", int'(rd_valid), 0);
    @(posedge clk);
    #1;
    live_rising = 1'b0;
    rd_ready    = 1'b0;
    exp_q.delete();
    mdl_wr      = 0;
    mdl_occ     = 0;
    mdl_waiting = 1'b0;
    checkOutput("live clear n_pileup", int'(n_pileup), 0);
    checkOutput("live clear rd_valid", int'(rd_valid), 0);
    checkOutput("live clear pointers", int'({rd_slot, wr_slot}), 0);

    $display("[TB] fill ring and overflow");
    for (int i = 0; i < 64; i++) applyStimulus(1, 0, 0, 0);
    checkOutput("full n_pileup", int'(n_pileup), 64);
    checkOutput("full wr_slot wrapped", int'(wr_slot), 0);
    checkOutput("no write_overflow yet", int'(write_overflow), 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("write_overflow set", int'(write_overflow), 1);
    checkOutput("overflow n_pileup held", int'(n_pileup), 64);
    checkOutput("overflow wr_slot held", int'(wr_slot), 0);
    checkOutput("stop when full", int'(stop), 1);

    $display("[TB] drain full ring at minimum cadence");
    for (int i = 0; i < 64; i++) begin
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 1, 0, 0);
      cyc(1);
    end
    checkOutput("drained n_pileup", int'(n_pileup), 0);
    checkOutput("drained rd_slot wrapped", int'(rd_slot), 0);
    checkOutput("write_overflow sticky", int'(write_overflow), 1);

    $display("[TB] simultaneous trigger and completion");
    applyStimulus(0, 0, 0, 1);
    checkOutput("write_overflow cleared", int'(write_overflow), 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("simul n_pileup", int'(n_pileup), 5);
    checkOutput("simul wr_slot", int'(wr_slot), 6);
    checkOutput("simul rd_slot", int'(rd_slot), 1);
    cyc(1);
    applyStimulus(0, 0, 1, 0);

`ifdef EVTSCHED_TIMEOUT_EN
    $display("[TB] read watchdog");
    cyc(RTO - 1);
    checkOutput("timeout_err before limit", int'(timeout_err), 0);
    checkOutput("n_pileup before timeout", int'(n_pileup), 5);
    cyc(1);
    mdl_occ--;
    mdl_waiting = 1'b0;
    checkOutput("timeout_err fired", int'(timeout_err), 1);
    checkOutput("timeout retires slot", int'(n_pileup), 4);
    cyc(1);
    checkOutput("next slot issued rd_valid", int'(rd_valid), 1);
    checkOutput("next slot issued rd_slot", int'(rd_slot), 2);
`else
    $display("[TB] WAIT held without watchdog");
    cyc(RTO + 4);
    checkOutput("WAIT held rd_valid", int'(rd_valid), 0);
    checkOutput("WAIT held n_pileup", int'(n_pileup), 5);
    checkOutput("timeout_err tied low", int'(timeout_err), 0);
`endif

    $display("[TB] read_complete outside WAIT");
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0);
    checkOutput("read_overflow set", int'(read_overflow), 1);
    checkOutput("read_overflow n_pileup", int'(n_pileup), 0);
    checkOutput("read_overflow rd_valid", int'(rd_valid), 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("flags cleared by live_rising", int'({write_overflow, read_overflow, timeout_err}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
